// File: rtl/key_switch_conditioner.sv
// Input conditioner for the stopwatch board: synchronises, debounces and
// edge-detects the push-buttons and mode switches, and keeps a sticky
// per-key press latch that firmware polls and acknowledges.
module key_switch_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int SW_WIDTH        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic [NUM_KEYS-1:0] key_clear,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_latch,
    output logic [SW_WIDTH-1:0] sw_level,
    output logic                sw_change
);

    // Keys and switches share one debounce datapath; keys occupy the low bits.
    localparam int NUM_IN = NUM_KEYS + SW_WIDTH;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic KEY_POL = (KEY_ACTIVE_LOW != 0);
    // Idle pin level; also the XOR mask that turns synchronised keys into 1 = pressed.
    localparam logic [NUM_IN-1:0] IDLE_LEVEL = {{SW_WIDTH{1'b0}}, {NUM_KEYS{KEY_POL}}};

    logic [NUM_IN-1:0] raw_all;
    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;
    logic [NUM_IN-1:0] norm;
    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] accept;
    logic [CW-1:0]     cnt [NUM_IN];

    logic [NUM_KEYS-1:0] key_accept;
    logic [NUM_KEYS-1:0] key_new;
    logic [NUM_KEYS-1:0] press_nxt;
    logic [NUM_KEYS-1:0] release_nxt;
    logic [SW_WIDTH-1:0] sw_accept;

    assign raw_all = {sw_raw, key_raw};
    assign norm    = sync2 ^ IDLE_LEVEL;

    // Two-flop synchroniser; resets to the idle pin level so reset looks like "nothing pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
        end
    end

    // An input is accepted on the edge where it has differed for the full count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            accept[i] = (norm[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign key_accept  = accept[NUM_KEYS-1:0];
    assign key_new     = norm[NUM_KEYS-1:0];
    assign press_nxt   = key_accept & key_new;
    assign release_nxt = key_accept & ~key_new;
    assign sw_accept   = accept[NUM_IN-1:NUM_KEYS];

    // Per-input stability counters; any return to the stable level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (norm[i] == stable[i] || cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels plus edge pulses, all updated on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable      <= '0;
            key_press   <= '0;
            key_release <= '0;
            sw_change   <= 1'b0;
        end else begin
            stable      <= stable ^ accept;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            sw_change   <= |sw_accept;
        end
    end

    // Sticky press flag: set by the registered press pulse, which wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_latch <= '0;
        end else begin
            key_latch <= key_press | (key_latch & ~key_clear);
        end
    end

    assign key_level = stable[NUM_KEYS-1:0];
    assign sw_level  = stable[NUM_IN-1:NUM_KEYS];

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with DEBOUNCE_CYCLES=4 and
// active-low keys; expected output vectors go through a scoreboard queue.
module tb_key_switch_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] key_raw;
    logic [1:0] sw_raw;
    logic [3:0] key_clear;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_latch;
    logic [1:0] sw_level;
    logic       sw_change;

    typedef struct {
        string      tag;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lat;
        logic [1:0] swl;
        logic       swc;
    } exp_t;

    exp_t sb[$];

    logic [3:0] exp_lvl;
    logic [3:0] exp_prs;
    logic [3:0] exp_rel;
    logic [3:0] exp_lat;
    logic [1:0] exp_swl;
    logic       exp_swc;

    int errors;
    int checks;

    key_switch_conditioner #(
        .NUM_KEYS(4),
        .SW_WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_raw(key_raw),
        .sw_raw(sw_raw),
        .key_clear(key_clear),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_latch(key_latch),
        .sw_level(sw_level),
        .sw_change(sw_change)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] k, input logic [1:0] s, input logic [3:0] c);
        key_raw   = k;
        sw_raw    = s;
        key_clear = c;
    endtask

    task automatic setExpect(input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel,
                             input logic [3:0] lat, input logic [1:0] swl, input logic swc);
        exp_lvl = lvl;
        exp_prs = prs;
        exp_rel = rel;
        exp_lat = lat;
        exp_swl = swl;
        exp_swc = swc;
    endtask

    task automatic pushExpect(input string tag);
        exp_t e;
        e.tag = tag;
        e.lvl = exp_lvl;
        e.prs = exp_prs;
        e.rel = exp_rel;
        e.lat = exp_lat;
        e.swl = exp_swl;
        e.swc = exp_swc;
        sb.push_back(e);
    endtask

    task automatic compareHead();
        exp_t e;
        logic [18:0] obs;
        logic [18:0] req;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e   = sb.pop_front();
            obs = {key_level, key_press, key_release, key_latch, sw_level, sw_change};
            req = {e.lvl, e.prs, e.rel, e.lat, e.swl, e.swc};
            assert (obs === req) else begin
                errors++;
                $error("[TB] FAIL %s: observed lvl=%b prs=%b rel=%b lat=%b swl=%b swc=%b expected lvl=%b prs=%b rel=%b lat=%b swl=%b swc=%b",
                       e.tag, key_level, key_press, key_release, key_latch, sw_level, sw_change,
                       e.lvl, e.prs, e.rel, e.lat, e.swl, e.swc);
            end
        end
    endtask

    // Push the current expectation, advance one clock, compare on the falling edge; n times.
    task automatic checkOutput(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            pushExpect(tag);
            @(posedge clk);
            @(negedge clk);
            compareHead();
        end
    endtask

    // Directed sequence of stimulus steps.
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        applyStimulus(4'hF, 2'b00, 4'h0);
        setExpect(4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        #2;
        pushExpect("reset_state");
        compareHead();
        @(negedge clk);
        reset = 1'b0;
        checkOutput(3, "idle");

        $display("[TB] clean press on key 0");
        applyStimulus(4'hE, 2'b00, 4'h0);
        checkOutput(5, "press0_wait");
        setExpect(4'b0001, 4'b0001, 4'h0, 4'h0, 2'b00, 1'b0);
        checkOutput(1, "press0_pulse");
        setExpect(4'b0001, 4'h0, 4'h0, 4'b0001, 2'b00, 1'b0);
        checkOutput(3, "press0_latch");

        $display("[TB] bounce on key 1");
        applyStimulus(4'hC, 2'b00, 4'h0);
        checkOutput(3, "bounce_low1");
        applyStimulus(4'hE, 2'b00, 4'h0);
        checkOutput(2, "bounce_high");
        applyStimulus(4'hC, 2'b00, 4'h0);
        checkOutput(3, "bounce_low2");
        applyStimulus(4'hE, 2'b00, 4'h0);
        checkOutput(8, "bounce_settle");

        $display("[TB] latch handshake on key 2");
        applyStimulus(4'hA, 2'b00, 4'h0);
        checkOutput(5, "press2_wait");
        setExpect(4'b0101, 4'b0100, 4'h0, 4'b0001, 2'b00, 1'b0);
        checkOutput(1, "press2_pulse");
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b00, 1'b0);
        checkOutput(2, "press2_latch");
        applyStimulus(4'hA, 2'b00, 4'b0100);
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0001, 2'b00, 1'b0);
        checkOutput(1, "clear2_held");
        applyStimulus(4'hA, 2'b00, 4'h0);
        checkOutput(3, "clear2_stays");
        applyStimulus(4'hE, 2'b00, 4'h0);
        checkOutput(5, "release2_wait");
        setExpect(4'b0001, 4'h0, 4'b0100, 4'b0001, 2'b00, 1'b0);
        checkOutput(1, "release2_pulse");
        setExpect(4'b0001, 4'h0, 4'h0, 4'b0001, 2'b00, 1'b0);
        checkOutput(1, "release2_done");
        applyStimulus(4'hA, 2'b00, 4'h0);
        checkOutput(5, "repress2_wait");
        setExpect(4'b0101, 4'b0100, 4'h0, 4'b0001, 2'b00, 1'b0);
        checkOutput(1, "repress2_pulse");
        applyStimulus(4'hA, 2'b00, 4'b0100);
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b00, 1'b0);
        checkOutput(1, "set_wins");
        applyStimulus(4'hA, 2'b00, 4'h0);
        checkOutput(2, "set_wins_hold");

        $display("[TB] switch changes");
        applyStimulus(4'hA, 2'b11, 4'h0);
        checkOutput(5, "sw11_wait");
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b11, 1'b1);
        checkOutput(1, "sw11_pulse");
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b11, 1'b0);
        checkOutput(2, "sw11_single");
        applyStimulus(4'hA, 2'b10, 4'h0);
        checkOutput(5, "sw10_wait");
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b10, 1'b1);
        checkOutput(1, "sw10_pulse");
        setExpect(4'b0101, 4'h0, 4'h0, 4'b0101, 2'b10, 1'b0);
        checkOutput(2, "sw10_done");

        $display("[TB] simultaneous keys");
        applyStimulus(4'hF, 2'b10, 4'h0);
        checkOutput(5, "rel02_wait");
        setExpect(4'h0, 4'h0, 4'b0101, 4'b0101, 2'b10, 1'b0);
        checkOutput(1, "rel02_pulse");
        setExpect(4'h0, 4'h0, 4'h0, 4'b0101, 2'b10, 1'b0);
        checkOutput(1, "rel02_done");
        applyStimulus(4'hF, 2'b10, 4'hF);
        setExpect(4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 1'b0);
        checkOutput(1, "clear_all");
        applyStimulus(4'h6, 2'b10, 4'h0);
        checkOutput(5, "press03_wait");
        setExpect(4'b1001, 4'b1001, 4'h0, 4'h0, 2'b10, 1'b0);
        checkOutput(1, "press03_pulse");
        setExpect(4'b1001, 4'h0, 4'h0, 4'b1001, 2'b10, 1'b0);
        checkOutput(1, "press03_latch");
        applyStimulus(4'hF, 2'b10, 4'h0);
        checkOutput(5, "rel03_wait");
        setExpect(4'h0, 4'h0, 4'b1001, 4'b1001, 2'b10, 1'b0);
        checkOutput(1, "rel03_pulse");
        setExpect(4'h0, 4'h0, 4'h0, 4'b1001, 2'b10, 1'b0);
        checkOutput(1, "rel03_done");

        $display("[TB] reset in the middle of a count");
        applyStimulus(4'hD, 2'b10, 4'h0);
        checkOutput(4, "mid_count");
        reset = 1'b1;
        #1;
        setExpect(4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        pushExpect("async_reset");
        compareHead();
        @(negedge clk);
        reset = 1'b0;
        checkOutput(5, "post_reset_wait");
        setExpect(4'b0010, 4'b0010, 4'h0, 4'h0, 2'b10, 1'b1);
        checkOutput(1, "post_reset_pulse");
        setExpect(4'b0010, 4'h0, 4'h0, 4'b0010, 2'b10, 1'b0);
        checkOutput(2, "post_reset_latch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
